// File: rtl/bids22defs.sv
// Shared opcode and error encodings for the bids22 auction controller and its host.
package bids22defs;
    typedef enum logic [3:0] {
        NO_OP        = 4'd0,
        UNLOCK       = 4'd1,
        LOCK         = 4'd2,
        LOADX        = 4'd3,
        LOADY        = 4'd4,
        LOADZ        = 4'd5,
        SETMASK      = 4'd6,
        SETTIMER     = 4'd7,
        SETBIDCHARGE = 4'd8
    } opcode_t;

    typedef enum logic [2:0] {
        NOERROR        = 3'd0,
        BADKEY         = 3'd1,
        INVALID_OP     = 3'd2,
        ALREADY_LOCKED = 3'd3,
        NOT_LOCKED     = 3'd4
    } err_t;
endpackage

// File: rtl/bids22_host_seq.sv
// Host-side command sequencer for bids22: takes one auction config, programs the
// controller, runs one timed round and reports the winning bid or a fault code.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | req_ready high, waiting for a config request
// S_UNLOCK   | driving UNLOCK with the latched key
// S_UNLK_CHK | NO_OP cycle; BADKEY seen here aborts with code 2
// S_LOAD     | six back-to-back load ops, ld_idx selects the one on the bus
// S_LOCK     | driving LOCK with the latched key
// S_WAITRDY  | NO_OP until ready, bounded by TIMEOUT (code 3)
// S_ROUND    | C_start high for max(round_len,1) cycles
// S_WAITOVER | waiting for roundOver, bounded by TIMEOUT (code 4)
// S_DONE     | one-cycle done pulse
// S_FAULT    | one-cycle fault pulse
module bids22_host_seq
    import bids22defs::*;
#(
    parameter int DATAWIDTH  = 32,
    parameter int NUMBIDDERS = 3,
    parameter int CNTW       = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATAWIDTH-1:0]  cfg_key,
    input  logic [DATAWIDTH-1:0]  cfg_x,
    input  logic [DATAWIDTH-1:0]  cfg_y,
    input  logic [DATAWIDTH-1:0]  cfg_z,
    input  logic [NUMBIDDERS-1:0] cfg_mask,
    input  logic [DATAWIDTH-1:0]  cfg_timer,
    input  logic [DATAWIDTH-1:0]  cfg_charge,
    input  logic [CNTW-1:0]       cfg_round_len,
    output opcode_t               C_op,
    output logic [DATAWIDTH-1:0]  C_data,
    output logic                  C_start,
    input  logic                  ready,
    input  err_t                  err,
    input  logic                  roundOver,
    input  logic [DATAWIDTH-1:0]  maxBid,
    output logic                  busy,
    output logic                  done,
    output logic [DATAWIDTH-1:0]  result_maxbid,
    output logic                  fault,
    output logic [2:0]            fault_code
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_UNLOCK,
        S_UNLK_CHK,
        S_LOAD,
        S_LOCK,
        S_WAITRDY,
        S_ROUND,
        S_WAITOVER,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [CNTW-1:0] TMO_LOAD = CNTW'(TIMEOUT);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    state_t                  state;
    logic [DATAWIDTH-1:0]    key_q;
    logic [DATAWIDTH-1:0]    x_q;
    logic [DATAWIDTH-1:0]    y_q;
    logic [DATAWIDTH-1:0]    z_q;
    logic [NUMBIDDERS-1:0]   mask_q;
    logic [DATAWIDTH-1:0]    timer_q;
    logic [DATAWIDTH-1:0]    charge_q;
    logic [CNTW-1:0]         len_q;
    logic [2:0]              ld_idx;
    logic [CNTW-1:0]         tmo_cnt;
    logic [CNTW-1:0]         round_cnt;
    logic                    dut_unlocked;

    opcode_t                 ld_next_op;
    logic [DATAWIDTH-1:0]    ld_next_data;

    // Operation that follows the one currently on the bus during LOAD; the
    // slot after SETBIDCHARGE is the LOCK command.
    always_comb begin
        ld_next_op   = LOCK;
        ld_next_data = key_q;
        case (ld_idx)
            3'd0: begin ld_next_op = LOADY;        ld_next_data = y_q;                 end
            3'd1: begin ld_next_op = LOADZ;        ld_next_data = z_q;                 end
            3'd2: begin ld_next_op = SETMASK;      ld_next_data = DATAWIDTH'(mask_q);  end
            3'd3: begin ld_next_op = SETTIMER;     ld_next_data = timer_q;             end
            3'd4: begin ld_next_op = SETBIDCHARGE; ld_next_data = charge_q;            end
            default: begin ld_next_op = LOCK;      ld_next_data = key_q;               end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            req_ready     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            fault         <= 1'b0;
            fault_code    <= 3'd0;
            result_maxbid <= '0;
            C_op          <= NO_OP;
            C_data        <= '0;
            C_start       <= 1'b0;
            dut_unlocked  <= 1'b1;
            key_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            z_q           <= '0;
            mask_q        <= '0;
            timer_q       <= '0;
            charge_q      <= '0;
            len_q         <= CNT_ONE;
            ld_idx        <= 3'd0;
            tmo_cnt       <= '0;
            round_cnt     <= '0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        key_q         <= cfg_key;
                        x_q           <= cfg_x;
                        y_q           <= cfg_y;
                        z_q           <= cfg_z;
                        mask_q        <= cfg_mask;
                        timer_q       <= cfg_timer;
                        charge_q      <= cfg_charge;
                        len_q         <= (cfg_round_len == '0) ? CNT_ONE : cfg_round_len;
                        fault_code    <= 3'd0;
                        result_maxbid <= '0;
                        req_ready     <= 1'b0;
                        busy          <= 1'b1;
                        ld_idx        <= 3'd0;
                        if (!dut_unlocked) begin
                            state  <= S_UNLOCK;
                            C_op   <= UNLOCK;
                            C_data <= cfg_key;
                        end else begin
                            state  <= S_LOAD;
                            C_op   <= LOADX;
                            C_data <= cfg_x;
                        end
                    end
                end
                S_UNLOCK: begin
                    state  <= S_UNLK_CHK;
                    C_op   <= NO_OP;
                    C_data <= '0;
                end
                S_UNLK_CHK: begin
                    if (err == BADKEY) begin
                        state      <= S_FAULT;
                        fault      <= 1'b1;
                        fault_code <= 3'd2;
                    end else begin
                        dut_unlocked <= 1'b1;
                        state        <= S_LOAD;
                        ld_idx       <= 3'd0;
                        C_op         <= LOADX;
                        C_data       <= x_q;
                    end
                end
                S_LOAD: begin
                    // The op on the bus this cycle is judged by this cycle's err.
                    if (err != NOERROR) begin
                        state      <= S_FAULT;
                        fault      <= 1'b1;
                        fault_code <= 3'd1;
                        C_op       <= NO_OP;
                        C_data     <= '0;
                    end else begin
                        C_op   <= ld_next_op;
                        C_data <= ld_next_data;
                        if (ld_idx == 3'd5) begin
                            state <= S_LOCK;
                        end else begin
                            ld_idx <= ld_idx + 3'd1;
                        end
                    end
                end
                S_LOCK: begin
                    dut_unlocked <= 1'b0;
                    state        <= S_WAITRDY;
                    C_op         <= NO_OP;
                    C_data       <= '0;
                    tmo_cnt      <= TMO_LOAD;
                end
                S_WAITRDY: begin
                    if (ready) begin
                        state     <= S_ROUND;
                        C_start   <= 1'b1;
                        round_cnt <= len_q;
                    end else if (tmo_cnt <= CNT_ONE) begin
                        state      <= S_FAULT;
                        fault      <= 1'b1;
                        fault_code <= 3'd3;
                    end else begin
                        tmo_cnt <= tmo_cnt - CNT_ONE;
                    end
                end
                S_ROUND: begin
                    if (round_cnt <= CNT_ONE) begin
                        state   <= S_WAITOVER;
                        C_start <= 1'b0;
                        tmo_cnt <= TMO_LOAD;
                    end else begin
                        round_cnt <= round_cnt - CNT_ONE;
                    end
                end
                S_WAITOVER: begin
                    if (roundOver) begin
                        state         <= S_DONE;
                        done          <= 1'b1;
                        fault_code    <= 3'd0;
                        result_maxbid <= maxBid;
                    end else if (tmo_cnt <= CNT_ONE) begin
                        state      <= S_FAULT;
                        fault      <= 1'b1;
                        fault_code <= 3'd4;
                    end else begin
                        tmo_cnt <= tmo_cnt - CNT_ONE;
                    end
                end
                S_DONE, S_FAULT: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    C_op      <= NO_OP;
                    C_data    <= '0;
                    C_start   <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    C_op      <= NO_OP;
                    C_data    <= '0;
                    C_start   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bids22_host_seq.sv
// Bench for bids22_host_seq: emulates the bids22 responses and compares every cycle
// against an expected command trace built from the sequencing rules.
module tb_bids22_host_seq;
    import bids22defs::*;

    localparam int DW  = 32;
    localparam int NB  = 3;
    localparam int CW  = 16;
    localparam int TMO = 1024;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] cfg_key = '0, cfg_x = '0, cfg_y = '0, cfg_z = '0;
    logic [NB-1:0] cfg_mask = '0;
    logic [DW-1:0] cfg_timer = '0, cfg_charge = '0;
    logic [CW-1:0] cfg_round_len = '0;
    opcode_t       C_op;
    logic [DW-1:0] C_data;
    logic          C_start;
    logic          ready = 1'b0;
    err_t          err = NOERROR;
    logic          roundOver = 1'b0;
    logic [DW-1:0] maxBid = '0;
    logic          busy, done, fault;
    logic [DW-1:0] result_maxbid;
    logic [2:0]    fault_code;

    bids22_host_seq #(.DATAWIDTH(DW), .NUMBIDDERS(NB), .CNTW(CW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .cfg_key(cfg_key), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_z(cfg_z), .cfg_mask(cfg_mask),
        .cfg_timer(cfg_timer), .cfg_charge(cfg_charge), .cfg_round_len(cfg_round_len),
        .C_op(C_op), .C_data(C_data), .C_start(C_start), .ready(ready), .err(err),
        .roundOver(roundOver), .maxBid(maxBid), .busy(busy), .done(done),
        .result_maxbid(result_maxbid), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        opcode_t       op;
        logic [DW-1:0] data;
        logic          cs, dn, ft, rdy, ovr, rst;
        err_t          e;
    } cyc_t;

    cyc_t tr[$];
    bit   model_unlocked = 1'b1;

    function automatic cyc_t idle_cyc();
        cyc_t c;
        c.op = NO_OP; c.data = '0; c.cs = 0; c.dn = 0; c.ft = 0;
        c.rdy = 0; c.ovr = 0; c.rst = 0; c.e = NOERROR;
        return c;
    endfunction

    // rdy_dly/ovr_dly < 0 means the response never comes; rst_at >= 0 resets in that round cycle.
    task automatic run_txn(input logic [DW-1:0] key, x, y, z, input logic [NB-1:0] mask,
                           input logic [DW-1:0] tmr, chg, input logic [CW-1:0] len,
                           input bit badkey, input int err_at, input int rdy_dly,
                           input int ovr_dly, input int rst_at, input logic [DW-1:0] mb);
        cyc_t          c;
        opcode_t       lops[6];
        logic [DW-1:0] ldat[6];
        int            exp_code = 0;
        bit            exp_done = 0, ended = 0, did_rst = 0;
        int            n;
        lops = '{LOADX, LOADY, LOADZ, SETMASK, SETTIMER, SETBIDCHARGE};
        ldat = '{x, y, z, DW'(mask), tmr, chg};
        tr.delete();
        if (!model_unlocked) begin
            c = idle_cyc(); c.op = UNLOCK; c.data = key; tr.push_back(c);
            c = idle_cyc(); if (badkey) c.e = BADKEY; tr.push_back(c);
            if (badkey) begin
                c = idle_cyc(); c.ft = 1; tr.push_back(c); exp_code = 2; ended = 1;
            end else model_unlocked = 1;
        end
        if (!ended) begin
            for (int i = 0; i < 6; i++) begin
                c = idle_cyc(); c.op = lops[i]; c.data = ldat[i];
                if (i == err_at) c.e = INVALID_OP;
                tr.push_back(c);
                if (i == err_at) begin
                    c = idle_cyc(); c.ft = 1; tr.push_back(c); exp_code = 1; ended = 1;
                    break;
                end
            end
        end
        if (!ended) begin
            c = idle_cyc(); c.op = LOCK; c.data = key; tr.push_back(c);
            model_unlocked = 0;
            if (rdy_dly < 0) begin
                for (int i = 0; i < TMO; i++) tr.push_back(idle_cyc());
                c = idle_cyc(); c.ft = 1; tr.push_back(c); exp_code = 3; ended = 1;
            end else begin
                for (int i = 0; i < rdy_dly; i++) tr.push_back(idle_cyc());
                c = idle_cyc(); c.rdy = 1; tr.push_back(c);
            end
        end
        if (!ended) begin
            n = (len == 0) ? 1 : int'(len);
            for (int k = 0; k < n; k++) begin
                c = idle_cyc(); c.cs = 1;
                if (k == rst_at) begin
                    c.rst = 1; tr.push_back(c); did_rst = 1; ended = 1;
                    break;
                end
                tr.push_back(c);
            end
        end
        if (!ended) begin
            if (ovr_dly < 0) begin
                for (int i = 0; i < TMO; i++) tr.push_back(idle_cyc());
                c = idle_cyc(); c.ft = 1; tr.push_back(c); exp_code = 4;
            end else begin
                for (int i = 0; i < ovr_dly; i++) tr.push_back(idle_cyc());
                c = idle_cyc(); c.ovr = 1; tr.push_back(c);
                c = idle_cyc(); c.dn = 1; tr.push_back(c); exp_done = 1;
            end
        end

        @(negedge clk);
        check("idle_req_ready", req_ready, 1);
        check("idle_busy", busy, 0);
        req_valid = 1; cfg_key = key; cfg_x = x; cfg_y = y; cfg_z = z; cfg_mask = mask;
        cfg_timer = tmr; cfg_charge = chg; cfg_round_len = len;

        for (int j = 0; j < tr.size(); j++) begin
            @(negedge clk);
            check("c_op", C_op, tr[j].op);
            check("c_data", C_data, tr[j].data);
            check("c_start", C_start, tr[j].cs);
            check("done", done, tr[j].dn);
            check("fault", fault, tr[j].ft);
            check("busy", busy, 1);
            check("req_ready_busy", req_ready, 0);
            if (tr[j].ft) check("fault_code", fault_code, exp_code);
            if (tr[j].dn) begin
                check("done_fault_code", fault_code, 0);
                check("result_maxbid", result_maxbid, mb);
            end
            // Requests while busy must be ignored, so keep throwing junk at the port.
            req_valid = (j == tr.size() - 1) ? 1'b0 : 1'($urandom % 2);
            cfg_key = $urandom; cfg_x = $urandom; cfg_y = $urandom; cfg_z = $urandom;
            cfg_mask = NB'($urandom); cfg_timer = $urandom; cfg_charge = $urandom;
            cfg_round_len = CW'($urandom);
            err = tr[j].e; ready = tr[j].rdy; roundOver = tr[j].ovr;
            maxBid = tr[j].ovr ? mb : $urandom;
            if (tr[j].rst) reset_n = 0;
        end

        @(negedge clk);
        err = NOERROR; ready = 0; roundOver = 0; req_valid = 0;
        check("end_c_start", C_start, 0);
        check("end_c_op", C_op, NO_OP);
        check("end_req_ready", req_ready, 1);
        check("end_busy", busy, 0);
        check("end_done", done, 0);
        check("end_fault", fault, 0);
        if (did_rst) begin
            check("rst_fault_code", fault_code, 0);
            check("rst_result", result_maxbid, 0);
            reset_n = 1;
            model_unlocked = 1;
        end else begin
            check("end_fault_code", fault_code, exp_code);
            if (exp_done) check("end_result", result_maxbid, mb);
        end
    endtask

    initial begin
        logic [DW-1:0] key;
        logic [DW-1:0] k2;
        reset_n = 0;
        repeat (3) @(negedge clk);
        check("rst_c_op", C_op, NO_OP);
        check("rst_c_data", C_data, 0);
        check("rst_c_start", C_start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_fault_code", fault_code, 0);
        check("rst_result", result_maxbid, 0);
        check("rst_req_ready", req_ready, 1);
        reset_n = 1;

        key = $urandom;
        // Fresh DUT is unlocked: straight to loads, 4-cycle round.
        run_txn(key, 100, 50, 20, 3'b111, $urandom, 1, 4, 0, -1, 2, 3, -1, $urandom);
        // Same key again: UNLOCK first.
        run_txn(key, $urandom, $urandom, $urandom, 3'b101, $urandom, $urandom, 3, 0, -1, 0, 0, -1, $urandom);
        // Wrong key rejected.
        k2 = key ^ 32'h1;
        run_txn(k2, $urandom, $urandom, $urandom, 3'b011, $urandom, $urandom, 2, 1, -1, 0, 0, -1, $urandom);
        // Unlock succeeds, LOADY rejected.
        run_txn(key, $urandom, $urandom, $urandom, 3'b110, $urandom, $urandom, 2, 0, 1, 0, 0, -1, $urandom);
        // ready never arrives.
        run_txn(key, $urandom, $urandom, $urandom, 3'b001, $urandom, $urandom, 5, 0, -1, -1, 0, -1, $urandom);
        // roundOver never arrives.
        run_txn(key, $urandom, $urandom, $urandom, 3'b010, $urandom, $urandom, 2, 0, -1, 1, -1, -1, $urandom);
        // Reset in the third round cycle of a 10-cycle round.
        run_txn(key, $urandom, $urandom, $urandom, 3'b111, $urandom, $urandom, 10, 0, -1, 1, 0, 2, $urandom);
        // Zero length runs as one cycle; also last SETBIDCHARGE error.
        run_txn(key, $urandom, $urandom, $urandom, 3'b100, $urandom, $urandom, 0, 0, -1, 0, 1, -1, $urandom);
        run_txn(key, $urandom, $urandom, $urandom, 3'b100, $urandom, $urandom, 1, 0, 5, 0, 1, -1, $urandom);

        for (int t = 0; t < 25; t++) begin
            bit bk;
            int ea;
            bk = !model_unlocked && ($urandom_range(0, 4) == 0);
            ea = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_txn($urandom, $urandom, $urandom, $urandom, NB'($urandom), $urandom, $urandom,
                    CW'($urandom_range(0, 8)), bk, ea, int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 6)), -1, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
